// File: rtl/fb_axi_rd_slave.sv
// AXI read-only slave that serves a synthetic framebuffer.
// One burst in flight at a time. Beats inside [FB_BASE, FB_BASE+FB_SIZE)
// return {~Aa[31:0], Aa[31:0]} (Aa = 8-byte aligned beat address); beats
// outside the window, or bursts with an unsupported type or size, return
// SLVERR with zero data but still deliver every beat of the burst.
module fb_axi_rd_slave #(
    parameter int unsigned           ADDR_WIDTH = 64,
    parameter int unsigned           DATA_WIDTH = 64,
    parameter logic [ADDR_WIDTH-1:0] FB_BASE    = ADDR_WIDTH'(64'h8000_0000),
    parameter logic [ADDR_WIDTH-1:0] FB_SIZE    = ADDR_WIDTH'(64'h0010_0000),
    parameter int unsigned           LATENCY    = 2
) (
    input  logic                  clk_a,
    input  logic                  reset_a,
    input  logic                  arvalid_i,
    output logic                  arready_o,
    input  logic [ADDR_WIDTH-1:0] araddr_i,
    input  logic [1:0]            arburst_i,
    input  logic [7:0]            arlen_i,
    input  logic [2:0]            arsize_i,
    output logic                  rvalid_o,
    input  logic                  rready_i,
    output logic [DATA_WIDTH-1:0] rdata_o,
    output logic [1:0]            rresp_o,
    output logic                  rlast_o,
    output logic                  busy_o
);

    // One extra bit so the window end cannot wrap when FB_BASE sits near the top.
    localparam logic [ADDR_WIDTH:0] FB_END = {1'b0, FB_BASE} + {1'b0, FB_SIZE};
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    // WAIT spans LATENCY-1 cycles; the counter runs down to zero inclusive.
    localparam logic [3:0] WAIT_INIT   = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DATA} state_t;

    state_t                  state_q;
    logic [ADDR_WIDTH-1:0]   addr_q;      // address of the beat currently presented / next to present
    logic [ADDR_WIDTH-1:0]   next_addr_d;
    logic [1:0]              burst_q;
    logic [2:0]              size_q;
    logic [7:0]              remain_q;    // beats left after the current one
    logic [3:0]              wait_q;
    logic                    arready_q;
    logic                    rvalid_q;
    logic                    rlast_q;
    logic                    busy_q;
    logic [DATA_WIDTH-1:0]   rdata_q;
    logic [1:0]              rresp_q;

    function automatic logic beat_err(input logic [ADDR_WIDTH-1:0] a,
                                      input logic [1:0]            burst,
                                      input logic [2:0]            size);
        return (a < FB_BASE) || ({1'b0, a} >= FB_END) || burst[1] || (size > 3'd3);
    endfunction

    function automatic logic [DATA_WIDTH-1:0] beat_data(input logic [ADDR_WIDTH-1:0] a);
        logic [31:0] aa;
        aa = {a[31:3], 3'b000};
        return DATA_WIDTH'({~aa, aa});
    endfunction

    // Address of the following beat: INCR steps by the beat size, anything else holds.
    always_comb begin
        next_addr_d = addr_q;
        if (burst_q == BURST_INCR)
            next_addr_d = addr_q + (ADDR_WIDTH'(1) << size_q);
    end

    // Burst FSM with all outputs registered.
    always_ff @(posedge clk_a or posedge reset_a) begin
        if (reset_a) begin
            state_q   <= S_IDLE;
            addr_q    <= '0;
            burst_q   <= '0;
            size_q    <= '0;
            remain_q  <= '0;
            wait_q    <= '0;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rlast_q   <= 1'b0;
            busy_q    <= 1'b0;
            rdata_q   <= '0;
            rresp_q   <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    arready_q <= 1'b1;
                    if (arvalid_i && arready_q) begin
                        addr_q    <= araddr_i;
                        burst_q   <= arburst_i;
                        size_q    <= arsize_i;
                        remain_q  <= arlen_i;
                        arready_q <= 1'b0;
                        busy_q    <= 1'b1;
                        if (LATENCY <= 1) begin
                            // No wait phase: present beat 0 straight away.
                            state_q  <= S_DATA;
                            rvalid_q <= 1'b1;
                            rlast_q  <= (arlen_i == 8'd0);
                            if (beat_err(araddr_i, arburst_i, arsize_i)) begin
                                rdata_q <= '0;
                                rresp_q <= RESP_SLVERR;
                            end else begin
                                rdata_q <= beat_data(araddr_i);
                                rresp_q <= RESP_OKAY;
                            end
                        end else begin
                            state_q <= S_WAIT;
                            wait_q  <= WAIT_INIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (wait_q == 4'd0) begin
                        state_q  <= S_DATA;
                        rvalid_q <= 1'b1;
                        rlast_q  <= (remain_q == 8'd0);
                        if (beat_err(addr_q, burst_q, size_q)) begin
                            rdata_q <= '0;
                            rresp_q <= RESP_SLVERR;
                        end else begin
                            rdata_q <= beat_data(addr_q);
                            rresp_q <= RESP_OKAY;
                        end
                    end else begin
                        wait_q <= wait_q - 4'd1;
                    end
                end
                S_DATA: begin
                    if (rready_i) begin
                        if (rlast_q) begin
                            state_q   <= S_IDLE;
                            rvalid_q  <= 1'b0;
                            rlast_q   <= 1'b0;
                            rdata_q   <= '0;
                            rresp_q   <= '0;
                            busy_q    <= 1'b0;
                            arready_q <= 1'b1;
                        end else begin
                            // Next beat back-to-back, no bubble.
                            addr_q   <= next_addr_d;
                            remain_q <= remain_q - 8'd1;
                            rlast_q  <= (remain_q == 8'd1);
                            if (beat_err(next_addr_d, burst_q, size_q)) begin
                                rdata_q <= '0;
                                rresp_q <= RESP_SLVERR;
                            end else begin
                                rdata_q <= beat_data(next_addr_d);
                                rresp_q <= RESP_OKAY;
                            end
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign arready_o = arready_q;
    assign rvalid_o  = rvalid_q;
    assign rlast_o   = rlast_q;
    assign busy_o    = busy_q;
    assign rdata_o   = rdata_q;
    assign rresp_o   = rresp_q;

endmodule
